servo_pwm_ramp: RTL
===================

Name: servo_pwm_ramp

Overview:
Multi-channel hobby-servo PWM generator with per-channel slew limiting. Generalises the switch-selected 0°/180° pulse-width block. Any pulse width in [MIN_PULSE, MAX_PULSE] can be written per channel through a write port. The block owns the 20 ms frame counter, ramps each channel's active width toward its target by at most STEP counts per frame, and drives the PWM pins directly. It sits between the user/control logic and the servo output pins on the 25 MHz fabric clock.

Parameters:
N_CH, 2, number of servo channels (1..16)
CNT_W, 19, width of frame counter and pulse-width values
PERIOD, 500000, frame length in clk_in cycles (20 ms @ 25 MHz)
MIN_PULSE, 7000, minimum legal width (0°)
MAX_PULSE, 52500, maximum legal width (180°)
RESET_PULSE, 7000, width loaded into target and current on reset
STEP, 500, max width change per frame; 0 = no slew limit (jump)

Ports:
clk_in  in  1  system clock, 25 MHz
rst  in  1  synchronous, active-high reset
wr_en  in  1  write strobe for a channel target, single-cycle
wr_ch  in  4  channel index for write
wr_width  in  CNT_W  requested pulse width in clk_in cycles
pwm_out  out  N_CH  servo PWM outputs, bit i = channel i
at_target  out  N_CH  bit i high when channel i active width equals its target
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (rst=1 at a clk_in edge): frame counter=0; every tgt[i]=cur[i]=RESET_PULSE; pwm_out=0; at_target=all 1; frame_tick=0. Reset mid-frame aborts the frame; the next frame starts at counter 0 the cycle after rst deasserts.
- Frame counter: counts 0..PERIOD-1, wraps to 0. frame_tick is registered: high exactly for the cycle where counter==PERIOD-1.
- PWM: pwm_out[i] is registered, = (counter < cur[i]). One-cycle latency from counter value to pin. High time = cur[i] cycles per frame. Period = exactly PERIOD cycles.
- Write: on wr_en with wr_ch < N_CH, tgt[wr_ch] <= clamp(wr_width, MIN_PULSE, MAX_PULSE). wr_ch >= N_CH is ignored with no state change. No back-pressure; writes are accepted every cycle. The last write before a tick wins.
- Slew update happens only on the frame_tick cycle, so cur changes between frames and no frame ever carries a truncated or extended pulse. For each i:
  - if cur<tgt: cur <= min(cur+STEP, tgt)
  - if cur>tgt: cur <= max(cur-STEP, tgt)
  - else unchanged
  - STEP=0: cur <= tgt.
- Simultaneous wr_en and frame_tick: slew uses the pre-write tgt. The new target is stored and takes effect at the following tick.
- Arithmetic: sum/difference is computed in CNT_W+1 bits before compare, so it never overflows or underflows.
- at_target[i] is registered, = (cur[i]==tgt[i]). It drops the cycle after a write that changes the target and rises the cycle after the tick that reaches it.
- Parameter legality (elaboration check): MIN_PULSE<=RESET_PULSE<=MAX_PULSE<PERIOD<2^CNT_W; N_CH<=16.

Decomposition:
- Shared package servo_pkg holds:
  - CLK_HZ=25_000_000
  - SERVO_PERIOD=500000
  - SERVO_MIN=7000
  - SERVO_MAX=52500
  - SERVO_CNT_W=19
  - the clamp function
- Top holds the frame counter, frame_tick and write decode.
- Sub-module servo_slew_channel is instantiated N_CH times. Each instance holds tgt/cur, the slew step, the compare to pwm_out and at_target.

Test Plan (bench parameters PERIOD=100, MIN=10, MAX=90, RESET=10, STEP=5, CNT_W=8, N_CH=2 unless stated):
1. Reset then idle 3 frames -> each channel is high exactly 10 cycles per 100; frame_tick pulses every 100 cycles; at_target=2'b11.
2. Write ch0=30 -> ch0 high-times 15, 20, 25, 30, 30 on successive frames; at_target[0] low until the tick reaching 30; ch1 stays at 10.
3. Write ch1=200 and ch0=2 -> clamped to 90 and 10; ch1 ramps in 5-count steps to 90 over 16 frames; ch0 unchanged; wr_ch=3 write leaves all state unchanged.
4. Write ch0=50 on the same cycle as frame_tick -> that tick leaves cur[0] unchanged; ramp begins at the next tick; no frame has a partial pulse.
5. Assert rst for 1 cycle at counter=57 while ch0 ramps -> counter restarts at 0; both channels return to 10; pwm_out low during the reset cycle.
6. STEP=0 variant: write ch0=80 -> next frame high-time is 80 in one step; at_target[0] high after that tick.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo timing constants and the pulse-width clamp used by the write path.
package servo_pkg;

    localparam int unsigned CLK_HZ       = 25_000_000;
    localparam int unsigned SERVO_PERIOD = 500000;
    localparam int unsigned SERVO_MIN    = 7000;
    localparam int unsigned SERVO_MAX    = 52500;
    localparam int unsigned SERVO_CNT_W  = 19;

    function automatic int unsigned clamp(input int unsigned v,
                                          input int unsigned lo,
                                          input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: target/current width, per-frame slew step, PWM compare and at-target flag.
module servo_slew_channel #(
    parameter int CNT_W       = 19,
    parameter int RESET_PULSE = 7000,
    parameter int STEP        = 500
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_width_i,
    input  logic             frame_tick_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             pwm_o,
    output logic             at_target_o
);

    localparam logic [CNT_W:0]   STEP_W  = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0] RESET_W = CNT_W'(RESET_PULSE);

    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] cur_q, cur_d;
    logic             pwm_q, at_q;
    logic [CNT_W:0]   upSum, dnBound, dnDiff;

    // Slew uses the registered target, so a write landing on the tick waits one frame.
    always_comb begin
        tgt_d   = wr_en_i ? wr_width_i : tgt_q;
        cur_d   = cur_q;
        upSum   = {1'b0, cur_q} + STEP_W;
        dnBound = {1'b0, tgt_q} + STEP_W;
        dnDiff  = {1'b0, cur_q} - STEP_W;
        if (frame_tick_i) begin
            if (STEP == 0) begin
                cur_d = tgt_q;
            end else if (cur_q < tgt_q) begin
                cur_d = (upSum >= {1'b0, tgt_q}) ? tgt_q : upSum[CNT_W-1:0];
            end else if (cur_q > tgt_q) begin
                cur_d = ({1'b0, cur_q} <= dnBound) ? tgt_q : dnDiff[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            tgt_q <= RESET_W;
            cur_q <= RESET_W;
            pwm_q <= 1'b0;
            at_q  <= 1'b1;
        end else begin
            tgt_q <= tgt_d;
            cur_q <= cur_d;
            pwm_q <= (cnt_i < cur_q);
            at_q  <= (cur_d == tgt_d);
        end
    end

    assign pwm_o       = pwm_q;
    assign at_target_o = at_q;

endmodule

// File: rtl/servo_pwm_ramp.sv
// Multi-channel servo PWM generator: shared frame counter and tick, write decode, N slew-limited channels.
module servo_pwm_ramp
    import servo_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CNT_W       = SERVO_CNT_W,
    parameter int PERIOD      = SERVO_PERIOD,
    parameter int MIN_PULSE   = SERVO_MIN,
    parameter int MAX_PULSE   = SERVO_MAX,
    parameter int RESET_PULSE = SERVO_MIN,
    parameter int STEP        = 500
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_ch,
    input  logic [CNT_W-1:0] wr_width,
    output logic [N_CH-1:0]  pwm_out,
    output logic [N_CH-1:0]  at_target,
    output logic             frame_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    if (!(MIN_PULSE <= RESET_PULSE && RESET_PULSE <= MAX_PULSE && MAX_PULSE < PERIOD &&
          PERIOD < (2 ** CNT_W) && N_CH >= 1 && N_CH <= 16)) begin : g_param_err
        $error("servo_pwm_ramp: illegal parameter combination");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;
    logic [CNT_W-1:0] wrClamped;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // The tick is registered off the next count so it lines up with counter == PERIOD-1.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign wrClamped  = CNT_W'(clamp(32'(wr_width), 32'(MIN_PULSE), 32'(MAX_PULSE)));
    assign frame_tick = tick_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_slew_channel #(
            .CNT_W      (CNT_W),
            .RESET_PULSE(RESET_PULSE),
            .STEP       (STEP)
        ) u_ch (
            .clk_in      (clk_in),
            .rst         (rst),
            .wr_en_i     (wr_en && (wr_ch == 4'(i))),
            .wr_width_i  (wrClamped),
            .frame_tick_i(tick_q),
            .cnt_i       (cnt_q),
            .pwm_o       (pwm_out[i]),
            .at_target_o (at_target[i])
        );
    end

endmodule
